// File: rtl/fix_to_float_12.sv
`default_nettype none
// ============================================================================
// Module   : fix_to_float_12
// Purpose  : Three-stage pipelined converter from signed two's-complement
//            fixed-point (DATA_W bits, FRAC_W fractional bits) to the 12-bit
//            float format {sign[11], exp[10:6] bias 15, man[5:0] hidden 1}.
//            Zero is exp=man=0; there are no denormals, infinities or NaN.
//            Values below the smallest exponent flush to +0 and values above
//            the largest exponent saturate to {sign, 0x7FF}.
// Build    : FIX_TO_FLOAT_12_ROUND_EN defined   -> round-half-up on the
//                                                  magnitude (no sticky bit)
//            FIX_TO_FLOAT_12_ROUND_EN undefined -> truncate the magnitude
// Ports    : clk_i    - clock, rising edge
//            rst_n_i  - asynchronous active-low reset
//            en_i     - pipeline advance; 0 holds every stage register
//            valid_i  - data_i qualifier
//            data_i   - signed fixed-point input, DATA_W bits
//            valid_o  - data_o qualifier, 3 enabled cycles after valid_i
//            data_o   - fp12 result
// Revision : 1.0 - initial release
// ============================================================================
module fix_to_float_12 #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [11:0]       data_o
);

  localparam int c_lead_w = $clog2(DATA_W);
  // Biased exponent is p - FRAC_W + 15 with p in 0..31 and FRAC_W in 0..31,
  // so -16..46 before rounding; 8 signed bits cover it with margin.
  localparam int                 c_exp_w   = 8;
  localparam logic signed [7:0]  c_exp_off = 8'(15 - FRAC_W);

  // --------------------------------------------------------------------------
  // Stage 1: sign and magnitude
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_s1_mag;
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [DATA_W-1:0] r_s1_mag;

  // The most-negative input negates to 2^(DATA_W-1), which still fits the
  // unsigned magnitude register.
  assign w_s1_mag = data_i[DATA_W-1] ? (~data_i + DATA_W'(1)) : data_i;

  // --------------------------------------------------------------------------
  // Stage 2: leading-one detect and normalize
  // --------------------------------------------------------------------------
  logic [c_lead_w-1:0]       w_lead;
  logic [c_lead_w-1:0]       w_shamt;
  logic [DATA_W-1:0]         w_norm;
  logic signed [c_exp_w-1:0] w_exp;
  logic [5:0]                w_man6;
  logic                      w_zero;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (r_s1_mag[i]) begin
        w_lead = c_lead_w'(i);
      end
    end
  end

  // Shift the leading one up to the MSB; the 6 bits under it are the
  // mantissa and the next one is the round bit.
  assign w_shamt = c_lead_w'(DATA_W - 1) - w_lead;
  assign w_norm  = r_s1_mag << w_shamt;
  assign w_man6  = 6'(w_norm >> (DATA_W - 7));
  assign w_exp   = $signed({{(c_exp_w - c_lead_w){1'b0}}, w_lead}) + c_exp_off;
  assign w_zero  = (r_s1_mag == '0);

  logic                      r_s2_valid;
  logic                      r_s2_sign;
  logic                      r_s2_zero;
  logic signed [c_exp_w-1:0] r_s2_exp;
  logic [5:0]                r_s2_man;
`ifdef FIX_TO_FLOAT_12_ROUND_EN
  logic                      w_rnd;
  logic                      r_s2_rnd;
  assign w_rnd = w_norm[DATA_W-8];
`endif

  // --------------------------------------------------------------------------
  // Stage 3: round, range check, pack
  // --------------------------------------------------------------------------
  logic signed [c_exp_w-1:0] w_exp_rnd;
  logic [5:0]                w_man_rnd;
  logic [11:0]               w_result;

`ifdef FIX_TO_FLOAT_12_ROUND_EN
  logic [6:0] w_man_sum;
  // Mantissa overflow (63 + 1) wraps to 0 and carries into the exponent.
  assign w_man_sum = {1'b0, r_s2_man} + {6'b0, r_s2_rnd};
  assign w_man_rnd = w_man_sum[5:0];
  assign w_exp_rnd = r_s2_exp + $signed({7'b0, w_man_sum[6]});
`else
  assign w_man_rnd = r_s2_man;
  assign w_exp_rnd = r_s2_exp;
`endif

  always_comb begin
    w_result = {r_s2_sign, w_exp_rnd[4:0], w_man_rnd};
    if (r_s2_zero || (w_exp_rnd < 8'sd1)) begin
      // Underflow flushes to positive zero.
      w_result = 12'h000;
    end else if (w_exp_rnd > 8'sd31) begin
      w_result = {r_s2_sign, 11'h7FF};
    end else if ((r_s2_exp == 8'sd31) && (r_s2_man == 6'd63)) begin
      // Largest magnitude is never incremented past itself.
      w_result = {r_s2_sign, 11'h7FF};
    end
  end

  logic        r_valid_o;
  logic [11:0] r_data_o;

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_man   <= '0;
`ifdef FIX_TO_FLOAT_12_ROUND_EN
      r_s2_rnd   <= 1'b0;
`endif
      r_valid_o  <= 1'b0;
      r_data_o   <= 12'h000;
    end else if (en_i) begin
      // Data registers load even for bubbles; only valid marks them.
      r_s1_valid <= valid_i;
      r_s1_sign  <= data_i[DATA_W-1];
      r_s1_mag   <= w_s1_mag;
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= w_zero;
      r_s2_exp   <= w_exp;
      r_s2_man   <= w_man6;
`ifdef FIX_TO_FLOAT_12_ROUND_EN
      r_s2_rnd   <= w_rnd;
`endif
      r_valid_o  <= r_s2_valid;
      r_data_o   <= w_result;
    end
  end

  assign valid_o = r_valid_o;
  assign data_o  = r_data_o;

endmodule
`default_nettype wire
